// File: rtl/mfp_seg_pkg.sv
// Shared definitions for the SWORD seven-segment serial driver.
//   FRAME_W   : bits per display frame (8 digits x 8 segments)
//   DIGITS    : number of digits in the chain
//   seg_state_t : driver FSM states
//   HEX7SEG   : nibble -> active-low {dp,g,f,e,d,c,b,a} pattern, dp off
package mfp_seg_pkg;

  localparam int FRAME_W = 64;
  localparam int DIGITS  = FRAME_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } seg_state_t;

  localparam logic [7:0] HEX7SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/mfp_hex7seg.sv
// Combinational encoder for one display digit.
//   i_nibble : hex value of the digit
//   i_dot    : 1 lights the decimal point
//   i_blank  : 1 turns the whole digit off (wins over value and dot)
//   o_seg    : active-low {dp,g,f,e,d,c,b,a}
module mfp_hex7seg
  import mfp_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dot,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = HEX7SEG[i_nibble];
    if (i_dot) begin
      o_seg[7] = 1'b0;
    end
    if (i_blank) begin
      o_seg = 8'hFF;
    end
  end

endmodule

// File: rtl/mfp_sword_seg_shift.sv
// Serial driver for the SWORD 8-digit seven-segment shift-register chain.
// Encodes value/dot/blank into a 64-bit active-low frame and shifts it out
// MSB first on a divided clock. Requests arriving mid-frame are held and
// sent once the current frame ends; reset queues a blank frame.
//   CLK_DIV    : SEG_CLK half-period in SI_ClkIn cycles (1..255)
//   SI_ClkIn   : system clock
//   SI_Reset   : synchronous reset, active-high
//   SEG_value  : 8 hex digits, nibble k -> digit k (digit 0 rightmost)
//   SEG_dot    : per-digit decimal point enable
//   SEG_blank  : per-digit blank
//   SEG_update : one-cycle request to show the current inputs
//   SEG_busy   : frame in progress (LOAD, SHIFT, LATCH)
//   SEG_CLK    : chain shift clock, data sampled on its rising edge
//   SEG_DOUT   : serial data
//   SEG_PEN    : display enable, held low while shifting
//   SEG_CLRN   : chain clear, active-low, released after reset
//
// state | meaning
// IDLE  | waiting for an update or a pending request
// LOAD  | frame and bit counter loaded from the encoder
// SHIFT | bits 63..0 shifted out, low phase then high phase per bit
// LATCH | one cycle with clock low and display enabled
module mfp_sword_seg_shift
  import mfp_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        SI_ClkIn,
  input  logic        SI_Reset,
  input  logic [31:0] SEG_value,
  input  logic [7:0]  SEG_dot,
  input  logic [7:0]  SEG_blank,
  input  logic        SEG_update,
  output logic        SEG_busy,
  output logic        SEG_CLK,
  output logic        SEG_DOUT,
  output logic        SEG_PEN,
  output logic        SEG_CLRN
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  seg_state_t           r_state;
  seg_state_t           w_state_nxt;

  logic [31:0]          r_cap_value;
  logic [7:0]           r_cap_dot;
  logic [7:0]           r_cap_blank;
  logic                 r_pend;
  logic [31:0]          r_pend_value;
  logic [7:0]           r_pend_dot;
  logic [7:0]           r_pend_blank;
  logic [FRAME_W-1:0]   r_shift;
  logic [5:0]           r_bitcnt;
  logic [7:0]           r_div;
  logic                 r_phase;
  logic                 r_shown;
  logic                 r_clrn;

  logic [FRAME_W-1:0]   w_frame;
  logic                 w_div_tc;
  logic                 w_bit_end;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mfp_hex7seg u_hex (
      .i_nibble (r_cap_value[4*g +: 4]),
      .i_dot    (r_cap_dot[g]),
      .i_blank  (r_cap_blank[g]),
      .o_seg    (w_frame[8*g +: 8])
    );
  end

  assign w_div_tc  = (r_div == DIV_LAST);
  assign w_bit_end = w_div_tc && r_phase;

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (SEG_update || r_pend) w_state_nxt = LOAD;
      LOAD:  w_state_nxt = SHIFT;
      SHIFT: if (w_bit_end && (r_bitcnt == 6'd0)) w_state_nxt = LATCH;
      LATCH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      r_cap_value  <= '0;
      r_cap_dot    <= '0;
      r_cap_blank  <= 8'hFF;
      // A blank frame is queued so the chain is cleared after every reset.
      r_pend       <= 1'b1;
      r_pend_value <= '0;
      r_pend_dot   <= '0;
      r_pend_blank <= 8'hFF;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_div        <= '0;
      r_phase      <= 1'b0;
      r_shown      <= 1'b0;
      r_clrn       <= 1'b0;
    end else begin
      r_clrn <= 1'b1;

      // A fresh update in IDLE is newer than anything pending, so it wins.
      if (r_state == IDLE) begin
        if (SEG_update) begin
          r_cap_value <= SEG_value;
          r_cap_dot   <= SEG_dot;
          r_cap_blank <= SEG_blank;
        end else if (r_pend) begin
          r_cap_value <= r_pend_value;
          r_cap_dot   <= r_pend_dot;
          r_cap_blank <= r_pend_blank;
        end
      end

      // An update landing in LOAD re-arms pending rather than being lost.
      if (SEG_update && (r_state != IDLE)) begin
        r_pend       <= 1'b1;
        r_pend_value <= SEG_value;
        r_pend_dot   <= SEG_dot;
        r_pend_blank <= SEG_blank;
      end else if (r_state == LOAD) begin
        r_pend <= 1'b0;
      end

      unique case (r_state)
        LOAD: begin
          r_shift  <= w_frame;
          r_bitcnt <= 6'd63;
          r_div    <= '0;
          r_phase  <= 1'b0;
        end
        SHIFT: begin
          if (w_div_tc) begin
            r_div <= '0;
            if (r_phase) begin
              r_phase  <= 1'b0;
              r_shift  <= {r_shift[FRAME_W-2:0], 1'b0};
              r_bitcnt <= r_bitcnt - 6'd1;
            end else begin
              r_phase <= 1'b1;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        LATCH: r_shown <= 1'b1;
        default: ;
      endcase
    end
  end

  assign SEG_busy = (r_state != IDLE);
  assign SEG_CLK  = (r_state == SHIFT) && r_phase;
  assign SEG_DOUT = (r_state == SHIFT) && r_shift[FRAME_W-1];
  assign SEG_PEN  = (r_state == LATCH) || ((r_state == IDLE) && r_shown);
  assign SEG_CLRN = r_clrn;

endmodule

// File: tb/tb_mfp_sword_seg_shift.sv
module tb_mfp_sword_seg_shift;

  logic        clk;
  logic        rst0, rst1;
  logic [31:0] value;
  logic [7:0]  dot, blank;
  logic        update;
  logic        busy0, sclk0, dout0, pen0, clrn0;
  logic        busy1, sclk1, dout1, pen1, clrn1;
  logic        sel;
  logic        obs_busy, obs_clk, obs_dout, obs_pen, obs_clrn;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dot;
    logic [7:0]  blank;
    logic [63:0] frame;
  } vec_t;
  vec_t vecs[5];

  mfp_sword_seg_shift #(.CLK_DIV(2)) dut (
    .SI_ClkIn(clk), .SI_Reset(rst0), .SEG_value(value), .SEG_dot(dot),
    .SEG_blank(blank), .SEG_update(update), .SEG_busy(busy0), .SEG_CLK(sclk0),
    .SEG_DOUT(dout0), .SEG_PEN(pen0), .SEG_CLRN(clrn0)
  );

  mfp_sword_seg_shift #(.CLK_DIV(1)) dut1 (
    .SI_ClkIn(clk), .SI_Reset(rst1), .SEG_value(value), .SEG_dot(dot),
    .SEG_blank(blank), .SEG_update(update), .SEG_busy(busy1), .SEG_CLK(sclk1),
    .SEG_DOUT(dout1), .SEG_PEN(pen1), .SEG_CLRN(clrn1)
  );

  assign obs_busy = sel ? busy1 : busy0;
  assign obs_clk  = sel ? sclk1 : sclk0;
  assign obs_dout = sel ? dout1 : dout0;
  assign obs_pen  = sel ? pen1  : pen0;
  assign obs_clrn = sel ? clrn1 : clrn0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame monitor: collects bits on SEG_CLK rising edges, checks DOUT is
  // held across each high phase, and scores the frame when busy drops.
  logic [63:0] mon_sr = '0;
  int          mon_bits = 0;
  bit          mon_stable = 1'b1;
  logic        prev_clk = 1'b0;
  logic        prev_dout = 1'b0;
  logic [63:0] exp_frame;

  always @(negedge clk) begin
    if (!obs_busy) begin
      if (mon_bits == 64) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h expected none", mon_sr);
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame_data", mon_sr, exp_frame);
          check("dout_stable", 64'(mon_stable), 64'd1);
        end
      end
      mon_bits   = 0;
      mon_stable = 1'b1;
    end else begin
      if (obs_clk && !prev_clk) begin
        if (obs_dout !== prev_dout) mon_stable = 1'b0;
        mon_sr = {mon_sr[62:0], obs_dout};
        mon_bits++;
      end else if (obs_clk && prev_clk && (obs_dout !== prev_dout)) begin
        mon_stable = 1'b0;
      end
    end
    prev_clk  = obs_clk;
    prev_dout = obs_dout;
  end

  // Starts one frame (update pulse, or reset release when upd=0) at cycle n
  // and watches it: busy length, first SEG_CLK rise, PEN and clock shape.
  task automatic watch(input int d, input bit upd, input logic [31:0] v,
                       input logic [7:0] dt, input logic [7:0] bl,
                       output int busy_n, output int rise_k, output bit pen_ok,
                       output bit clk_ok, output logic first_clrn);
    bit   last_pen;
    logic exp_clk;
    @(negedge clk);
    if (upd) begin
      value = v; dot = dt; blank = bl; update = 1'b1;
    end else if (sel) begin
      rst1 = 1'b0;
    end else begin
      rst0 = 1'b0;
    end
    busy_n = 0; rise_k = -1; pen_ok = 1'b1; clk_ok = 1'b1;
    last_pen = 1'b0; first_clrn = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      update = 1'b0;
      if (k == 1) first_clrn = obs_clrn;
      exp_clk = (k >= 2 && k < 2 + 128 * d) ? ((((k - 2) / d) % 2) == 1) : 1'b0;
      if (obs_clk !== exp_clk) clk_ok = 1'b0;
      if (obs_busy) begin
        busy_n++;
        if (last_pen) pen_ok = 1'b0;
        last_pen = obs_pen;
        if (rise_k < 0 && obs_clk) rise_k = k;
      end else begin
        break;
      end
    end
    if (!last_pen) pen_ok = 1'b0;
  endtask

  // First frame from an update at k=0, extra update pulses at ka and kb.
  task automatic pulses(input logic [31:0] v0, input int ka, input logic [31:0] va,
                        input int kb, input logic [31:0] vb,
                        output int frames, output int gap);
    logic prev_busy;
    @(negedge clk);
    value = v0; dot = 8'h00; blank = 8'h00; update = 1'b1;
    frames = 0; gap = 0; prev_busy = 1'b0;
    for (int k = 1; k < 800; k++) begin
      @(negedge clk);
      update = 1'b0;
      if (k == ka) begin value = va; update = 1'b1; end
      if (k == kb) begin value = vb; update = 1'b1; end
      if (obs_busy && !prev_busy) frames++;
      if (!obs_busy && frames == 1) gap++;
      prev_busy = obs_busy;
    end
  endtask

  int   busy_n, rise_k, frames, gap;
  bit   pen_ok, clk_ok;
  logic fclrn;

  initial begin
    vecs[0] = '{32'h00000008, 8'h00, 8'h00, 64'hC0C0C0C0C0C0C080};
    vecs[1] = '{32'hDEADBEEF, 8'h01, 8'hF0, 64'hFFFFFFFF8386860E};
    vecs[2] = '{32'h76543210, 8'hFF, 8'h00, 64'h7802121930247940};
    vecs[3] = '{32'hFEDCBA98, 8'hAA, 8'h55, 64'h0EFF21FF03FF10FF};
    vecs[4] = '{32'h12345678, 8'h00, 8'h00, 64'hF9A4B0999282F880};

    rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
    update = 1'b0; value = '0; dot = '0; blank = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(obs_busy), 64'd0);
    check("rst_clk",  64'(obs_clk),  64'd0);
    check("rst_dout", 64'(obs_dout), 64'd0);
    check("rst_pen",  64'(obs_pen),  64'd0);
    check("rst_clrn", 64'(obs_clrn), 64'd0);

    // Automatic blank frame after reset release.
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    watch(2, 1'b0, '0, '0, '0, busy_n, rise_k, pen_ok, clk_ok, fclrn);
    check("rel_clrn",  64'(fclrn), 64'd1);
    check("rel_busy",  64'(busy_n), 64'd258);
    check("rel_rise",  64'(rise_k), 64'd4);
    check("rel_pen",   64'(pen_ok), 64'd1);
    check("rel_clk",   64'(clk_ok), 64'd1);
    check("idle_pen",  64'(obs_pen), 64'd1);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].frame);
      watch(2, 1'b1, vecs[i].value, vecs[i].dot, vecs[i].blank,
            busy_n, rise_k, pen_ok, clk_ok, fclrn);
      check("vec_busy", 64'(busy_n), 64'd258);
      check("vec_rise", 64'(rise_k), 64'd4);
      check("vec_pen",  64'(pen_ok), 64'd1);
      check("vec_clk",  64'(clk_ok), 64'd1);
    end

    // Two mid-frame requests: only the last one follows, after one idle cycle.
    exp_q.push_back(64'hC0C0C0C0C0C0C0C0);
    exp_q.push_back(64'h908883C6A1868EC0);
    pulses(32'h00000000, 20, 32'h12345678, 40, 32'h9ABCDEF0, frames, gap);
    check("mid_frames", 64'(frames), 64'd2);
    check("mid_gap",    64'(gap),    64'd1);

    // Request landing exactly in LATCH (k = 2 + 128*2).
    exp_q.push_back(64'hC0C0C0C0C0C0C0F9);
    exp_q.push_back(64'h8888888892929292);
    pulses(32'h00000001, 258, 32'hAAAA5555, -1, 32'h0, frames, gap);
    check("latch_frames", 64'(frames), 64'd2);
    check("latch_gap",    64'(gap),    64'd1);

    // Reset during the high phase of bit 30.
    @(negedge clk);
    value = 32'h11111111; dot = '0; blank = '0; update = 1'b1;
    for (int k = 1; k <= 136; k++) begin
      @(negedge clk);
      update = 1'b0;
    end
    check("b30_clk_hi", 64'(obs_clk), 64'd1);
    rst0 = 1'b1;
    @(negedge clk);
    check("abort_clk",  64'(obs_clk),  64'd0);
    check("abort_busy", 64'(obs_busy), 64'd0);
    check("abort_pen",  64'(obs_pen),  64'd0);
    check("abort_clrn", 64'(obs_clrn), 64'd0);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    watch(2, 1'b0, '0, '0, '0, busy_n, rise_k, pen_ok, clk_ok, fclrn);
    check("abort_rel_busy", 64'(busy_n), 64'd258);
    check("abort_rel_clk",  64'(clk_ok), 64'd1);

    // CLK_DIV = 1 instance.
    rst0 = 1'b1;
    sel  = 1'b1;
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    watch(1, 1'b0, '0, '0, '0, busy_n, rise_k, pen_ok, clk_ok, fclrn);
    check("d1_rel_busy", 64'(busy_n), 64'd130);
    check("d1_rel_clk",  64'(clk_ok), 64'd1);
    check("d1_rel_clrn", 64'(fclrn),  64'd1);
    exp_q.push_back(vecs[2].frame);
    watch(1, 1'b1, vecs[2].value, vecs[2].dot, vecs[2].blank,
          busy_n, rise_k, pen_ok, clk_ok, fclrn);
    check("d1_busy", 64'(busy_n), 64'd130);
    check("d1_rise", 64'(rise_k), 64'd3);
    check("d1_pen",  64'(pen_ok), 64'd1);
    check("d1_clk",  64'(clk_ok), 64'd1);

    repeat (5) @(negedge clk);
    check("frames_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
